// File: rtl/vector_lsu_agu_if.sv
// Banked vector memory port bundle: per-lane read/write strobes, addresses and data.
interface vector_lsu_agu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_ELEM   = 16
);
  logic [NUM_ELEM-1:0]            read_req;
  logic [ADDR_WIDTH*NUM_ELEM-1:0] read_addr;
  logic [DATA_WIDTH*NUM_ELEM-1:0] read_data;
  logic [NUM_ELEM-1:0]            write_req;
  logic [ADDR_WIDTH*NUM_ELEM-1:0] write_addr;
  logic [DATA_WIDTH*NUM_ELEM-1:0] write_data;

  modport master (
    output read_req, read_addr, write_req, write_addr, write_data,
    input  read_data
  );

  modport slave (
    input  read_req, read_addr, write_req, write_addr, write_data,
    output read_data
  );
endinterface

// File: rtl/vector_lsu_agu.sv
// Strided vector load/store address generator and sequencer for a banked memory.
// Optional lane bounds check against MEM_DEPTH is enabled by VLSU_BOUNDS_CHECK_EN.
module vector_lsu_agu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_ELEM   = 16,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_store,
  input  logic [ADDR_WIDTH-1:0]          cmd_base,
  input  logic [ADDR_WIDTH-1:0]          cmd_stride,
  input  logic [NUM_ELEM-1:0]            cmd_mask,
  input  logic [DATA_WIDTH*NUM_ELEM-1:0] cmd_wdata,
  vector_lsu_agu_if.master               mem,
  output logic                           ld_valid,
  input  logic                           ld_ready,
  output logic [DATA_WIDTH*NUM_ELEM-1:0] ld_data,
  output logic [NUM_ELEM-1:0]            oob_mask,
  output logic                           busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, RESP, WRITE} state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH*NUM_ELEM-1:0] lane_addr;
  logic [NUM_ELEM-1:0]            eff_mask;
  logic [ADDR_WIDTH*NUM_ELEM-1:0] addr_q;
  logic [NUM_ELEM-1:0]            mask_q;
  logic [DATA_WIDTH*NUM_ELEM-1:0] wdata_q;
  logic [DATA_WIDTH*NUM_ELEM-1:0] ld_data_q;
  logic [DATA_WIDTH*NUM_ELEM-1:0] data_keep;
  logic                           accept;

  assign accept = cmd_valid & cmd_ready;

  // Two's-complement stride: plain modular multiply-add gives the signed result.
  always_comb begin
    lane_addr = '0;
    for (int unsigned i = 0; i < NUM_ELEM; i++) begin
      lane_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = cmd_base + ADDR_WIDTH'(i) * cmd_stride;
    end
  end

`ifdef VLSU_BOUNDS_CHECK_EN
  logic [NUM_ELEM-1:0] lane_oob;
  logic [NUM_ELEM-1:0] oob_q;

  always_comb begin
    lane_oob = '0;
    for (int unsigned i = 0; i < NUM_ELEM; i++) begin
      lane_oob[i] = lane_addr[i*ADDR_WIDTH +: ADDR_WIDTH] >= ADDR_WIDTH'(MEM_DEPTH);
    end
  end

  assign eff_mask = cmd_mask & ~lane_oob;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oob_q <= '0;
    end else if (accept) begin
      oob_q <= lane_oob;
    end
  end

  assign oob_mask = oob_q;
`else
  assign eff_mask = cmd_mask;
  assign oob_mask = '0;
`endif

  always_comb begin
    data_keep = '0;
    for (int unsigned i = 0; i < NUM_ELEM; i++) begin
      data_keep[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{mask_q[i]}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      mask_q    <= '0;
      wdata_q   <= '0;
      ld_data_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= lane_addr;
        mask_q  <= eff_mask;
        wdata_q <= cmd_wdata;
      end
      if (state == CAPTURE) begin
        ld_data_q <= mem.read_data & data_keep;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    cmd_ready     = 1'b0;
    ld_valid      = 1'b0;
    mem.read_req  = '0;
    mem.write_req = '0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          next_state = cmd_store ? WRITE : ISSUE;
        end
      end
      ISSUE: begin
        mem.read_req = mask_q;
        next_state   = CAPTURE;
      end
      CAPTURE: begin
        next_state = RESP;
      end
      RESP: begin
        ld_valid = 1'b1;
        if (ld_ready) begin
          next_state = IDLE;
        end
      end
      WRITE: begin
        mem.write_req = mask_q;
        next_state    = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign busy           = (state != IDLE);
  assign ld_data        = ld_data_q;
  assign mem.read_addr  = addr_q;
  assign mem.write_addr = addr_q;
  assign mem.write_data = wdata_q;

endmodule

// File: tb/tb_vector_lsu_agu.sv
// Randomized self-checking bench for vector_lsu_agu against a lane-level behavioural model.
module tb_vector_lsu_agu;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int NE    = 16;
  localparam int DEPTH = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_store;
  logic [AW-1:0]     cmd_base;
  logic [AW-1:0]     cmd_stride;
  logic [NE-1:0]     cmd_mask;
  logic [DW*NE-1:0]  cmd_wdata;
  logic              ld_valid;
  logic              ld_ready;
  logic [DW*NE-1:0]  ld_data;
  logic [NE-1:0]     oob_mask;
  logic              busy;

  always #5 clk = ~clk;

  vector_lsu_agu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ELEM(NE)) bus ();

  vector_lsu_agu #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ELEM(NE), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_mask(cmd_mask),
    .cmd_wdata(cmd_wdata), .mem(bus),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .oob_mask(oob_mask), .busy(busy)
  );

  // Memory environment: 4K words, preloaded so an unwritten address a reads back a.
  logic [31:0]      mem [4096];
  logic             mem_loaded = 1'b0;
  logic [DW*NE-1:0] rdata;

  always @(posedge clk) begin
    logic [31:0] ra;
    logic [31:0] wa;
    if (!mem_loaded) begin
      for (int j = 0; j < 4096; j++) mem[j] <= 32'(j);
      mem_loaded <= 1'b1;
    end
    for (int i = 0; i < NE; i++) begin
      ra = bus.read_addr[i*AW +: AW];
      wa = bus.write_addr[i*AW +: AW];
      if (bus.read_req[i]) rdata[i*DW +: DW] <= mem[ra[11:0]] ^ {ra[31:12], 12'h000};
      else                 rdata[i*DW +: DW] <= $urandom;
      if (bus.write_req[i]) mem[wa[11:0]] <= bus.write_data[i*DW +: DW] ^ {wa[31:12], 12'h000};
    end
  end
  assign bus.read_data = rdata;

  // Reference model: sparse word memory where an unwritten address a holds a.
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a;
  endfunction

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [NE-1:0]    last_req;
  logic [DW*NE-1:0] last_ld;

  task automatic run_cmd(input bit store, input logic [31:0] base, input logic [31:0] stride,
                         input logic [NE-1:0] mask, input logic [DW*NE-1:0] wdata,
                         input int stall, input bit abort);
    logic [AW*NE-1:0] exp_addr;
    logic [DW*NE-1:0] exp_data;
    logic [NE-1:0]    exp_oob;
    logic [NE-1:0]    exp_eff;
    logic [31:0]      a;
    exp_oob = '0;
    exp_data = '0;
    for (int i = 0; i < NE; i++) begin
      a = base + 32'(i) * stride;
      exp_addr[i*AW +: AW] = a;
`ifdef VLSU_BOUNDS_CHECK_EN
      exp_oob[i] = (a >= 32'(DEPTH));
`endif
    end
    exp_eff = mask & ~exp_oob;

    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_store = store; cmd_base = base;
    cmd_stride = stride; cmd_mask = mask; cmd_wdata = wdata;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy", busy, 1'b1);
    check("cmd_ready_busy", cmd_ready, 1'b0);
    check("oob_mask", oob_mask, exp_oob);
    if (store) begin
      last_req = bus.write_req;
      check("write_req", bus.write_req, exp_eff);
      check("write_addr", bus.write_addr, exp_addr);
      check("write_data", bus.write_data, wdata);
      check("read_req_store", bus.read_req, '0);
      for (int i = 0; i < NE; i++)
        if (exp_eff[i]) ref_mem[exp_addr[i*AW +: AW]] = wdata[i*DW +: DW];
      @(negedge clk);
      check("write_req_drop", bus.write_req, '0);
      check("cmd_ready_after_store", cmd_ready, 1'b1);
    end else begin
      last_req = bus.read_req;
      check("read_req", bus.read_req, exp_eff);
      check("read_addr", bus.read_addr, exp_addr);
      check("write_req_load", bus.write_req, '0);
      for (int i = 0; i < NE; i++)
        if (exp_eff[i]) exp_data[i*DW +: DW] = ref_rd(exp_addr[i*AW +: AW]);
      @(negedge clk);
      check("read_req_drop", bus.read_req, '0);
      check("ld_valid_early", ld_valid, 1'b0);
      @(negedge clk);
      check("ld_valid", ld_valid, 1'b1);
      check("ld_data", ld_data, exp_data);
      last_ld = ld_data;
      for (int k = 0; k < stall; k++) begin
        cmd_valid = 1'b1; cmd_store = 1'($urandom); cmd_base = $urandom;
        cmd_stride = $urandom; cmd_mask = 16'($urandom);
        @(negedge clk);
        check("ld_valid_stall", ld_valid, 1'b1);
        check("ld_data_stall", ld_data, exp_data);
        check("cmd_ready_stall", cmd_ready, 1'b0);
      end
      cmd_valid = 1'b0;
      if (abort) begin
        #2 reset = 1'b0;
        #1;
        check("abort_ld_valid", ld_valid, 1'b0);
        check("abort_cmd_ready", cmd_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_ld_data", ld_data, '0);
        @(negedge clk);
        reset = 1'b1;
      end else begin
        ld_ready = 1'b1;
        @(negedge clk);
        ld_ready = 1'b0;
        check("ld_valid_drop", ld_valid, 1'b0);
        check("cmd_ready_after_load", cmd_ready, 1'b1);
      end
    end
  endtask

  initial begin
    logic [DW*NE-1:0] wd;
    logic [31:0]      lane;
    reset = 1'b0; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_base = '0;
    cmd_stride = '0; cmd_mask = '0; cmd_wdata = '0; ld_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_read_req", bus.read_req, '0);
    check("rst_write_req", bus.write_req, '0);
    check("rst_ld_valid", ld_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ld_data", ld_data, '0);
    check("rst_read_addr", bus.read_addr, '0);
    check("rst_write_data", bus.write_data, '0);
    check("rst_oob", oob_mask, '0);
    reset = 1'b1;

    // Unit-stride load.
    run_cmd(1'b0, 32'd0, 32'd1, 16'hFFFF, '0, 0, 1'b0);
    lane = last_ld[3*DW +: DW];
    check("unit_lane3", lane, 32'd3);
    lane = last_ld[15*DW +: DW];
    check("unit_lane15", lane, 32'd15);

    // Negative-stride masked store, then readback.
    for (int i = 0; i < NE; i++) wd[i*DW +: DW] = 32'hA0 + 32'(i);
    run_cmd(1'b1, 32'd100, 32'hFFFF_FFFE, 16'h00F0, wd, 0, 1'b0);
    lane = bus.write_addr[7*AW +: AW];
    check("neg_stride_lane7", lane, 32'd86);
    run_cmd(1'b0, 32'd100, 32'hFFFF_FFFE, 16'hFFFF, '0, 0, 1'b0);
    lane = last_ld[5*DW +: DW];
    check("readback_lane5", lane, 32'hA5);

    // All-zero mask load.
    run_cmd(1'b0, 32'd40, 32'd3, 16'h0000, '0, 1, 1'b0);
    check("zero_mask_req", last_req, 16'h0000);

    // Stall then reset abort in RESP.
    run_cmd(1'b0, 32'd8, 32'd2, 16'h5A5A, '0, 5, 1'b1);

    // Reset while strobing in ISSUE.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_store = 1'b0; cmd_base = 32'd0; cmd_stride = 32'd1; cmd_mask = 16'hFFFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("issue_req", bus.read_req, 16'hFFFF);
    #2 reset = 1'b0;
    #1;
    check("issue_abort_req", bus.read_req, '0);
    check("issue_abort_ready", cmd_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;

    // Address wrap.
    run_cmd(1'b0, 32'hFFFF_FFFE, 32'd1, 16'hFFFF, '0, 0, 1'b0);
    lane = bus.read_addr[2*AW +: AW];
    check("wrap_lane2", lane, 32'h0000_0000);
    lane = bus.read_addr[15*AW +: AW];
    check("wrap_lane15", lane, 32'h0000_000D);

    // Bounds check at the top of memory.
    run_cmd(1'b0, 32'd1020, 32'd1, 16'hFFFF, '0, 0, 1'b0);
`ifdef VLSU_BOUNDS_CHECK_EN
    check("bounds_oob", oob_mask, 16'hFFF0);
    check("bounds_req", last_req, 16'h000F);
    lane = last_ld[4*DW +: DW];
    check("bounds_lane4", lane, 32'd0);
`else
    check("bounds_oob", oob_mask, 16'h0000);
    check("bounds_req", last_req, 16'hFFFF);
`endif

    // Randomized mix of loads and stores.
    for (int n = 0; n < 60; n++) begin
      logic        st;
      logic [31:0] b;
      logic [31:0] s;
      st = 1'($urandom);
      b  = $urandom_range(0, 1100);
      s  = $urandom_range(0, 80) - 32'd40;
      if (st && s == 0) s = 32'd1;
      for (int i = 0; i < NE; i++) wd[i*DW +: DW] = $urandom;
      run_cmd(st, b, s, 16'($urandom), wd, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vector_lsu_agu.md
# vector_lsu_agu

- Vector load/store address-generation and sequencing stage that sits directly upstream of the banked vector memory.
- Accepts one strided vector command at a time and expands it into per-lane addresses and per-lane request strobes for the memory's NUM_ELEM independent ports.
- For loads, captures the returned lane data and presents it on a valid/ready response port.

## Interface
Parameters:
- DATA_WIDTH, 32, lane data width
- ADDR_WIDTH, 32, lane address width
- NUM_ELEM, 16, lanes per vector (= memory banks)
- MEM_DEPTH, 1024, words per bank; used only by the bounds check

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_store  in  1  0 = load, 1 = store
- cmd_base  in  ADDR_WIDTH  lane-0 address
- cmd_stride  in  ADDR_WIDTH  signed two's-complement lane stride
- cmd_mask  in  NUM_ELEM  lane enable
- cmd_wdata  in  DATA_WIDTH*NUM_ELEM  store data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- read_req  out  NUM_ELEM  per-lane read strobe to memory
- read_addr  out  ADDR_WIDTH*NUM_ELEM  per-lane read address
- read_data  in  DATA_WIDTH*NUM_ELEM  memory data, valid one cycle after read_req
- write_req  out  NUM_ELEM  per-lane write strobe
- write_addr  out  ADDR_WIDTH*NUM_ELEM  per-lane write address
- write_data  out  DATA_WIDTH*NUM_ELEM  per-lane write data
- ld_valid  out  1  load response valid
- ld_ready  in  1  response accepted
- ld_data  out  DATA_WIDTH*NUM_ELEM  load result
- oob_mask  out  NUM_ELEM  lanes suppressed by the bounds check
- busy  out  1  state != IDLE

## Operation
- **Command handshake.** A command is accepted on cmd_valid & cmd_ready. At acceptance the block registers the lane addresses, the effective mask, and the write data.
- **Lane address.** addr_i = cmd_base + i*cmd_stride, truncated to ADDR_WIDTH. Results wrap modulo 2^ADDR_WIDTH and no overflow is flagged.
- **Effective mask.** The effective mask is cmd_mask with bounds-check lanes cleared (see Configuration).
- **State machine:**
  - IDLE: cmd_ready = 1. On a load accept, go to ISSUE. On a store accept, go to WRITE.
  - ISSUE: read_req = effective mask and read_addr = the registered addresses, for one cycle. Go to CAPTURE.
  - CAPTURE: register read_data into ld_data. Lanes with effective mask 0 are forced to 0. Go to RESP.
  - RESP: ld_valid = 1 and ld_data is held stable. On ld_ready, go to IDLE.
  - WRITE: write_req = effective mask, with write_addr and write_data driven, for one cycle. Go to IDLE.
- **Idle outputs.** read_req and write_req are 0 in every state other than the one that asserts them. read_addr, write_addr and write_data hold their last registered values.
- **All-zero effective mask.** The command still walks the full state sequence with identical latency but issues no strobes. A load with an all-zero mask returns all-zero ld_data.
- **Back-to-back commands.** Commands never overlap. Until the block returns to IDLE, cmd_ready is 0 and cmd_* inputs are ignored.

## Timing
- **Reset values.** While reset = 0:
  - state is IDLE and cmd_ready = 1;
  - read_req, write_req, ld_valid and busy are 0;
  - all address, data and ld_data registers and oob_mask are 0.
- **Reset mid-operation.** Asserting reset in any state forces IDLE asynchronously. An in-flight load response is discarded, and strobes drop in the same cycle that reset asserts.
- **Load latency.** Accept at cycle N gives read_req at N+1, capture at the end of N+2, and ld_valid from N+3. If ld_ready is high at N+3, cmd_ready is high at N+4.
- **Store latency.** Accept at cycle N gives write_req at N+1, and cmd_ready is high at N+2.
- **Peak throughput.** One load per 4 cycles; one store per 2 cycles.
- **Response stability.** ld_valid stays high and ld_data stays stable until ld_ready is sampled high, for any stall length.
- **Memory read latency.** The memory's read latency is fixed at exactly one cycle and the block provides no other tolerance.

## Configuration
- Feature macro: VLSU_BOUNDS_CHECK_EN.
- **Defined.** At acceptance, any lane with addr_i >= MEM_DEPTH is removed from the effective mask and its oob_mask bit is set. Such a lane issues no strobe, and a load returns 0 for it. oob_mask is registered at acceptance and held until the next accept.
- **Undefined.** oob_mask is tied to 0, the effective mask equals cmd_mask, and no comparison logic is built.

## Test plan
- **Unit-stride load.** Load with base=0, stride=1, mask=all ones on a memory preloaded with mem[a]=a. Required: read_req=0xFFFF at N+1, read_addr lane i = i, ld_valid at N+3, ld_data lane i = i.
- **Negative-stride masked store.** Store with base=100, stride=-2 (0xFFFFFFFE), mask=0x00F0, wdata lane i = 0xA0+i. Required: write_req=0x00F0 at N+1 only, write_addr lanes 4..7 = 92, 90, 88, 86, then a readback load matches.
- **Response stall and reset abort.** Hold ld_ready=0 for 5 cycles after ld_valid. Required: ld_data stable throughout, cmd_ready=0, and a cmd_valid offered meanwhile is ignored. Then assert reset mid-RESP. Required: ld_valid=0 immediately, cmd_ready=1.
- **All-zero mask.** Load with mask=0. Required: no read_req, ld_valid at N+3, ld_data=0.
- **Address wrap.** base=0xFFFFFFFE, stride=1. Required: lane 2 address = 0x00000000 and lane 15 = 0x0000000D.
- **Bounds check (macro defined).** MEM_DEPTH=1024, base=1020, stride=1, all ones. Required: oob_mask=0xFFF0, read_req=0x000F, ld_data lanes 4..15 = 0. With the macro undefined, oob_mask=0 and read_req=0xFFFF.
